datapath_controller: RTL

Moore FSM that sequences the 16-bit Datapath (ALU, 2:1 mux, 16x16 register file, 256x16 data memory).
- Owns the program counter (PC) and instruction register (IR).
- Fetches 16-bit instructions from a synchronous-read instruction ROM and decodes opcode IR[15:12].
- Drives every Datapath control input: D_addr, D_wr, RF_sel, RF_W_en, WriteAddr, rdAddrA, rdAddrB, ALU_s0.

---
 rtl/datapath_controller.sv | 115 +++++++++++
 1 files changed

// File: rtl/datapath_controller.sv
// Moore sequencer for the 16-bit datapath: owns PC/IR, fetches from a sync ROM, decodes IR[15:12].
// Control outputs are a pure decode of the registered state and IR; no handshake, the datapath never stalls.
module datapath_controller #(
  parameter int         PC_WIDTH = 7,
  parameter logic [2:0] ALU_ADD  = 3'd1,
  parameter logic [2:0] ALU_SUB  = 3'd2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         I_data,
  output logic [PC_WIDTH-1:0] I_addr,
  output logic                I_rd,
  output logic [7:0]          D_addr,
  output logic                D_wr,
  output logic                RF_sel,
  output logic                RF_W_en,
  output logic [3:0]          WriteAddr,
  output logic [3:0]          rdAddrA,
  output logic [3:0]          rdAddrB,
  output logic [2:0]          ALU_s0,
  output logic                halted,
  output logic [3:0]          state_out
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD_A = 4'd3,
    S_LOAD_B = 4'd4,
    S_STORE  = 4'd5,
    S_ADD    = 4'd6,
    S_SUB    = 4'd7,
    S_NOOP   = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [15:0]         ir;

  // Dispatch uses the ROM word arriving this cycle; IR only holds it from EXEC onwards.
  function automatic state_t dispatch(input logic [3:0] opcode);
    case (opcode)
      4'b0001: dispatch = S_STORE;
      4'b0010: dispatch = S_LOAD_A;
      4'b0011: dispatch = S_ADD;
      4'b0100: dispatch = S_SUB;
      4'b0101: dispatch = S_HALT;
      default: dispatch = S_NOOP;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_INIT;
      pc    <= '0;
      ir    <= '0;
    end else begin
      case (state)
        S_INIT:   state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          ir    <= I_data;
          pc    <= pc + 1'b1;
          state <= dispatch(I_data[15:12]);
        end
        S_LOAD_A: state <= S_LOAD_B;
        S_HALT:   state <= S_HALT;
        default:  state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    I_rd      = 1'b0;
    D_addr    = '0;
    D_wr      = 1'b0;
    RF_sel    = 1'b0;
    RF_W_en   = 1'b0;
    WriteAddr = '0;
    rdAddrA   = '0;
    rdAddrB   = '0;
    ALU_s0    = '0;
    halted    = 1'b0;
    case (state)
      S_FETCH: I_rd = 1'b1;
      // LOAD_A only presents the address; the RAM word is ready for the write in LOAD_B.
      S_LOAD_A, S_LOAD_B: begin
        D_addr    = ir[11:4];
        RF_sel    = 1'b1;
        WriteAddr = ir[3:0];
        RF_W_en   = (state == S_LOAD_B);
      end
      S_STORE: begin
        D_addr  = ir[7:0];
        rdAddrA = ir[11:8];
        D_wr    = 1'b1;
      end
      S_ADD, S_SUB: begin
        rdAddrA   = ir[11:8];
        rdAddrB   = ir[7:4];
        WriteAddr = ir[3:0];
        ALU_s0    = (state == S_ADD) ? ALU_ADD : ALU_SUB;
        RF_W_en   = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign I_addr    = pc;
  assign state_out = state;

endmodule
